btn_event_counter: RTL and testbench
====================================

# btn_event_counter

Parametrised multi-channel pushbutton front end and event counter for the Nexys-4 button test designs. Each of N_CH raw button inputs is synchronised and debounced, and converted to single-cycle event pulses, with optional hold-to-repeat. The pulses drive a shared WIDTH-bit up/down counter whose value feeds the seven-segment display interface.

## Interface
- N_CH, 4: number of button channels (1..8)
- WIDTH, 16: counter width in bits
- DEBOUNCE_CYC, 50000: consecutive stable cycles needed to accept a level change (10 ms at 5 MHz); minimum 2
- REPEAT_DELAY, 2500000: cycles from accepted press to the first repeat pulse (0.5 s)
- REPEAT_RATE, 500000: cycles between later repeat pulses (0.1 s)
- DIR_DOWN, {N_CH{1'b0}}: per-channel bit; 1 means that channel's pulses decrement the counter
- SATURATE, 0: 0 means the counter wraps modulo 2^WIDTH; 1 means it clamps at 0 and 2^WIDTH-1

Ports:
- clk5  input  1  5 MHz system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- raw  input  N_CH  asynchronous button levels, active high
- repeat_en  input  N_CH  per-channel auto-repeat enable, sampled each cycle
- clean  output  N_CH  debounced level per channel
- pulse  output  N_CH  one-cycle event strobe per channel
- count  output  WIDTH  counter value
- changed  output  1  one-cycle strobe, high in the cycle count takes a new value

## Operation
- Reset: sync flops, clean, pulse, all timers, count and changed all go to 0. Reset wins over every other event in that cycle.
- Synchroniser: a 2-flop chain per channel produces sync[i]. Nothing downstream uses raw directly.
- Debounce, per channel:
  - A timer counts while sync != clean and clears whenever sync == clean.
  - When the timer reaches DEBOUNCE_CYC-1 and sync != clean still holds, clean takes the sync value at the next edge and the timer clears.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes clean.
- Press pulse: pulse[i] is 1 in the first cycle clean[i] is 1 (registered in parallel with clean). A release produces no pulse.
- Auto-repeat, per channel. States are IDLE, HOLD and REPEAT.
  - IDLE to HOLD: on the press pulse, with the repeat timer cleared.
  - HOLD to REPEAT: the timer reaches REPEAT_DELAY-1 with repeat_en[i]=1. This emits one pulse and clears the timer.
  - REPEAT: emits a pulse every REPEAT_RATE cycles.
  - Any state to IDLE: clean[i]=0 or repeat_en[i]=0. No further pulses are emitted.
  - repeat_en is ignored in IDLE.
- Counter:
  - delta = (number of pulse bits with DIR_DOWN=0) minus (number with DIR_DOWN=1), evaluated on the same-cycle pulse vector.
  - delta is a signed value, clog2(N_CH+1)+1 bits wide. The sum is computed at WIDTH+2 bits.
  - Wrap mode: count takes the result modulo 2^WIDTH.
  - Saturate mode: results below 0 become 0; results above max become 2^WIDTH-1.
- changed is 1 exactly when the new count differs from the old one. delta=0 from opposing simultaneous pulses, and a clamp that holds the value, both give changed=0.
- Reset released while a button is held: clean rises after the normal debounce. That is treated as a fresh press and gives one pulse.

## Timing
- raw edge to sync: 2 cycles.
- Stable raw edge to clean: 2+DEBOUNCE_CYC cycles.
- pulse is in the same cycle as the clean rise.
- count and changed update 1 cycle after pulse, so press to count is 3+DEBOUNCE_CYC cycles.
- First repeat pulse: REPEAT_DELAY cycles after the press pulse. Later repeat pulses are REPEAT_RATE cycles apart.
- Throughput: one counter update per cycle. Pulses are never queued or dropped.

## Test plan
All cases use DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_CH=4, WIDTH=4, DIR_DOWN=4'b0010.
- Clean press on ch0, held 20 cycles with repeat_en=0 -> clean[0] rises 6 cycles after raw, one pulse, count 0 to 1, changed high for 1 cycle.
- Bounce on ch0 (raw toggling every 2 cycles for 12 cycles, then stable high) -> exactly one pulse, count=1.
- ch0 held 30 cycles with repeat_en[0]=1 -> pulses at press+0, +10, +13, +16, ..., none after release.
- ch0 and ch1 pressed on the same cycle -> both pulses together, count unchanged, changed=0.
- Wrap mode: count=15 then a ch0 press -> 0. From 0, a ch1 press -> 15.
- SATURATE=1: count=0 and ch1 pressed -> stays 0, changed=0. Reset asserted mid-hold then released -> count=0, and one new pulse after 6 cycles.

Source files
------------

// File: rtl/btn_event_counter.sv
// Multi-channel pushbutton front end: synchronise, debounce, press/auto-repeat
// event pulses, and a shared up/down event counter with wrap or clamp behaviour.
module btn_event_counter #(
  parameter int unsigned     N_CH         = 4,
  parameter int unsigned     WIDTH        = 16,
  parameter int unsigned     DEBOUNCE_CYC = 50000,
  parameter int unsigned     REPEAT_DELAY = 2500000,
  parameter int unsigned     REPEAT_RATE  = 500000,
  parameter logic [N_CH-1:0] DIR_DOWN     = '0,
  parameter bit              SATURATE     = 1'b0
) (
  input  logic             clk5,
  input  logic             reset,
  input  logic [N_CH-1:0]  raw,
  input  logic [N_CH-1:0]  repeat_en,
  output logic [N_CH-1:0]  clean,
  output logic [N_CH-1:0]  pulse,
  output logic [WIDTH-1:0] count,
  output logic             changed
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int unsigned RT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RT_W   = (RT_MAX > 1) ? $clog2(RT_MAX) : 1;
  localparam int unsigned DW     = $clog2(N_CH + 1) + 1;
  localparam int unsigned SW     = WIDTH + 2;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RT_W-1:0]  RD_LAST = RT_W'(REPEAT_DELAY - 1);
  localparam logic [RT_W-1:0]  RR_LAST = RT_W'(REPEAT_RATE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RPT_IDLE = 2'd0,
    RPT_HOLD = 2'd1,
    RPT_RUN  = 2'd2
  } rpt_state_e;

  logic [N_CH-1:0]  sync1_q;
  logic [N_CH-1:0]  sync_q;
  logic [N_CH-1:0]  clean_q;
  logic [N_CH-1:0]  clean_d;
  logic [N_CH-1:0]  pulse_q;
  logic [N_CH-1:0]  pulse_d;
  logic [DB_W-1:0]  db_cnt_q [N_CH];
  logic [DB_W-1:0]  db_cnt_d [N_CH];
  rpt_state_e       rpt_state_q [N_CH];
  rpt_state_e       rpt_state_d [N_CH];
  logic [RT_W-1:0]  rpt_cnt_q [N_CH];
  logic [RT_W-1:0]  rpt_cnt_d [N_CH];
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             changed_q;
  logic             changed_d;

  logic [N_CH-1:0]  press_c;
  logic [N_CH-1:0]  rpt_fire_c;
  logic [DW-1:0]    up_c;
  logic [DW-1:0]    dn_c;
  logic signed [DW-1:0] delta_c;
  logic signed [SW-1:0] sum_c;

  // Two-flop synchroniser; raw is never used past this point.
  always_ff @(posedge clk5) begin
    if (reset) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync_q  <= sync1_q;
    end
  end

  // Debounce: accept a level once it has differed from clean for DEBOUNCE_CYC cycles.
  always_comb begin
    clean_d = clean_q;
    press_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != clean_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          clean_d[i] = sync_q[i];
          press_c[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Auto-repeat next state; a repeat is only emitted if the button is still held next cycle.
  always_comb begin
    rpt_fire_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i] + RT_W'(1);
      case (rpt_state_q[i])
        RPT_IDLE: begin
          rpt_cnt_d[i] = '0;
          if (press_c[i]) begin
            rpt_state_d[i] = RPT_HOLD;
          end
        end
        RPT_HOLD: begin
          if (!clean_d[i] || !repeat_en[i]) begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end else if (rpt_cnt_q[i] == RD_LAST) begin
            rpt_fire_c[i]  = 1'b1;
            rpt_state_d[i] = RPT_RUN;
            rpt_cnt_d[i]   = '0;
          end
        end
        RPT_RUN: begin
          if (!clean_d[i] || !repeat_en[i]) begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end else if (rpt_cnt_q[i] == RR_LAST) begin
            rpt_fire_c[i] = 1'b1;
            rpt_cnt_d[i]  = '0;
          end
        end
        default: begin
          rpt_state_d[i] = RPT_IDLE;
          rpt_cnt_d[i]   = '0;
        end
      endcase
    end
    pulse_d = press_c | rpt_fire_c;
  end

  // Counter update from the registered pulse vector.
  always_comb begin
    up_c = '0;
    dn_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (pulse_q[i]) begin
        if (DIR_DOWN[i]) begin
          dn_c = dn_c + DW'(1);
        end else begin
          up_c = up_c + DW'(1);
        end
      end
    end
    delta_c = $signed(up_c) - $signed(dn_c);
    sum_c   = $signed({2'b00, count_q}) + SW'(delta_c);
    if (SATURATE) begin
      if (sum_c[SW-1]) begin
        count_d = '0;
      end else if (sum_c[WIDTH]) begin
        count_d = CNT_MAX;
      end else begin
        count_d = sum_c[WIDTH-1:0];
      end
    end else begin
      count_d = sum_c[WIDTH-1:0];
    end
    changed_d = (count_d != count_q);
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        rpt_state_q[i] <= RPT_IDLE;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
      end
    end
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      clean_q   <= '0;
      pulse_q   <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      clean_q   <= clean_d;
      pulse_q   <= pulse_d;
      count_q   <= count_d;
      changed_q <= changed_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  assign clean   = clean_q;
  assign pulse   = pulse_q;
  assign count   = count_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_btn_event_counter.sv
// Bench for btn_event_counter: wrap and saturate instances on shared stimulus,
// compared every cycle against a timestamp-based behavioural model.
module tb_btn_event_counter;

  localparam int unsigned N_CH = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;
  localparam logic [3:0]  DIRD = 4'b0010;

  logic       clk5 = 1'b0;
  logic       reset;
  logic [3:0] raw;
  logic [3:0] repeat_en;
  logic [3:0] clean_w, pulse_w, count_w, clean_s, pulse_s, count_s;
  logic       changed_w, changed_s;

  always #5 clk5 = ~clk5;

  btn_event_counter #(.N_CH(N_CH), .WIDTH(WIDTH), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD),
                      .REPEAT_RATE(RR), .DIR_DOWN(DIRD), .SATURATE(1'b0)) u_dut_wrap (
    .clk5(clk5), .reset(reset), .raw(raw), .repeat_en(repeat_en),
    .clean(clean_w), .pulse(pulse_w), .count(count_w), .changed(changed_w));

  btn_event_counter #(.N_CH(N_CH), .WIDTH(WIDTH), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD),
                      .REPEAT_RATE(RR), .DIR_DOWN(DIRD), .SATURATE(1'b1)) u_dut_sat (
    .clk5(clk5), .reset(reset), .raw(raw), .repeat_en(repeat_en),
    .clean(clean_s), .pulse(pulse_s), .count(count_s), .changed(changed_s));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference state: delayed raw samples, mismatch run lengths, press timestamps.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_pulse = '0;
  int         m_run [4] = '{0, 0, 0, 0};
  bit         m_alive [4] = '{0, 0, 0, 0};
  int         m_tp [4] = '{0, 0, 0, 0};
  int         cyc = 0;
  int         m_cw = 0, m_cs = 0;
  bit         m_chw = 0, m_chs = 0;

  task automatic model_step();
    int d, nw, ns, age;
    logic [3:0] nclean, npulse;
    cyc++;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_pulse = '0;
      m_cw = 0; m_cs = 0; m_chw = 0; m_chs = 0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_alive[i] = 0;
      end
      return;
    end
    d = 0;
    for (int i = 0; i < 4; i++) if (m_pulse[i]) d += DIRD[i] ? -1 : 1;
    nw = ((m_cw + d) % 16 + 16) % 16;
    ns = m_cs + d;
    if (ns < 0) ns = 0;
    if (ns > 15) ns = 15;
    m_chw = (nw != m_cw);
    m_chs = (ns != m_cs);
    m_cw = nw;
    m_cs = ns;
    nclean = m_clean;
    npulse = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_clean[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          nclean[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_alive[i]) begin
        if (!repeat_en[i] || !nclean[i]) m_alive[i] = 0;
        else begin
          age = cyc - m_tp[i];
          if (age >= RD && ((age - RD) % RR) == 0) npulse[i] = 1'b1;
        end
      end
      if (nclean[i] && !m_clean[i]) begin
        npulse[i] = 1'b1;
        m_alive[i] = 1;
        m_tp[i] = cyc;
      end
    end
    m_clean = nclean;
    m_pulse = npulse;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] en, input logic rst);
    raw = r;
    repeat_en = en;
    reset = rst;
    model_step();
    @(negedge clk5);
    chk("clean_w", clean_w, m_clean);
    chk("pulse_w", pulse_w, m_pulse);
    chk("count_w", count_w, m_cw);
    chk("changed_w", changed_w, m_chw);
    chk("clean_s", clean_s, m_clean);
    chk("pulse_s", pulse_s, m_pulse);
    chk("count_s", count_s, m_cs);
    chk("changed_s", changed_s, m_chs);
  endtask

  task automatic hold(input logic [3:0] r, input logic [3:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(r, en, 1'b0);
  endtask

  initial begin
    logic [3:0] rr;
    logic [3:0] re;
    int thr [6] = '{3, 8, 15, 2, 30, 5};

    for (int k = 0; k < 3; k++) cycle(4'b0000, 4'b0000, 1'b1);
    hold(4'b0000, 4'b0000, 3);

    // ch1 (down) press from zero: wrap to 15, clamp at 0
    hold(4'b0010, 4'b0000, 10);
    hold(4'b0000, 4'b0000, 10);
    chk("b_count_w", count_w, 15);
    chk("b_count_s", count_s, 0);

    // ch0 press: 15 wraps to 0
    hold(4'b0001, 4'b0000, 20);
    hold(4'b0000, 4'b0000, 10);
    chk("c_count_w", count_w, 0);
    chk("c_count_s", count_s, 1);

    // bounce then stable high: one pulse only
    for (int k = 0; k < 12; k++) cycle((k % 4) < 2 ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
    hold(4'b0001, 4'b0000, 15);
    hold(4'b0000, 4'b0000, 10);
    chk("d_count_w", count_w, 1);
    chk("d_count_s", count_s, 2);

    // hold with repeat: press plus seven repeats before clean falls
    hold(4'b0001, 4'b0001, 30);
    hold(4'b0000, 4'b0001, 12);
    hold(4'b0000, 4'b0000, 3);
    chk("e_count_w", count_w, 9);
    chk("e_count_s", count_s, 10);

    // simultaneous up and down presses cancel
    hold(4'b0011, 4'b0000, 12);
    hold(4'b0000, 4'b0000, 10);
    chk("f_count_w", count_w, 9);
    chk("f_count_s", count_s, 10);

    // reset mid-hold, released while still held: one fresh press
    hold(4'b0100, 4'b0000, 10);
    cycle(4'b0100, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b1);
    hold(4'b0100, 4'b0000, 12);
    hold(4'b0000, 4'b0000, 10);
    chk("g_count_w", count_w, 1);
    chk("g_count_s", count_s, 1);

    // random segments with different bounce densities
    rr = '0;
    re = '0;
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < 500; k++) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 99) < thr[s]) rr[i] = ~rr[i];
          if ($urandom_range(0, 99) < 3) re[i] = ~re[i];
        end
        cycle(rr, re, ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
